// File: rtl/cond_logic_pipe.sv
// Conditional-execution unit: evaluates the ARM cond field against grouped NZCV flags,
// gates PC/register/memory strobes with valid/stall/flush, and keeps saturating profiling counters.
module cond_logic_pipe #(
  parameter int FLAG_GROUPS = 2,
  parameter int NV_ALWAYS   = 0,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Valid,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [3:0]             Conditional,
  input  logic [3:0]             ALUFlags,
  input  logic [FLAG_GROUPS-1:0] FlagW,
  input  logic                   PCS,
  input  logic                   RegW,
  input  logic                   MemW,
  input  logic                   NoWrite,
  input  logic                   CntClr,
  output logic                   PCSource,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   CondEx,
  output logic [3:0]             Flags,
  output logic [CNT_W-1:0]       ExecCount,
  output logic [CNT_W-1:0]       SquashCount
);

  generate
    if (!(FLAG_GROUPS == 1 || FLAG_GROUPS == 2 || FLAG_GROUPS == 4)) begin : g_bad_groups
      $error("cond_logic_pipe: FLAG_GROUPS must be 1, 2 or 4");
    end
  endgenerate

  localparam int GW = 4 / FLAG_GROUPS;

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic             n_f, z_f, c_f, v_f;
  logic             commit, go;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    CondEx = 1'b0;
    case (Conditional)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = !z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = !c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = !n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = !v_f;
      4'b1000: CondEx = c_f && !z_f;
      4'b1001: CondEx = !c_f || z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = !z_f && (n_f == v_f);
      4'b1101: CondEx = z_f || (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      default: CondEx = (NV_ALWAYS != 0);
    endcase
  end

  assign commit   = Valid && !Stall && !Flush;
  assign go       = commit && CondEx;
  assign PCSource = PCS && go;
  assign MemWrite = MemW && go;
  assign RegWrite = RegW && !NoWrite && go;

  // Each flag bit follows the write-enable of the group that owns it.
  always_comb begin
    flags_d = flags_q;
    for (int unsigned b = 0; b < 4; b++) begin
      if (go && FlagW[b / GW]) flags_d[b] = ALUFlags[b];
    end
  end

  always_comb begin
    exec_d   = exec_q;
    squash_d = squash_q;
    if (CntClr) begin
      exec_d   = '0;
      squash_d = '0;
    end else begin
      if (go && exec_q != '1)                       exec_d   = exec_q + CNT_W'(1);
      if (commit && !CondEx && squash_q != '1)      squash_d = squash_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign Flags       = flags_q;
  assign ExecCount   = exec_q;
  assign SquashCount = squash_q;

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Directed bench for cond_logic_pipe: a default instance plus a CNT_W=2 / NV_ALWAYS=1 instance.
module tb_cond_logic_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid1, valid2, stall, flush;
  logic [3:0] cond, alu;
  logic [1:0] flagw;
  logic       pcs, regw, memw, nowrite, cntclr;

  logic        pc1, rw1, mw1, ce1;
  logic [3:0]  fl1;
  logic [15:0] ex1, sq1;
  logic        pc2, rw2, mw2, ce2;
  logic [3:0]  fl2;
  logic [1:0]  ex2, sq2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cond_logic_pipe #(.FLAG_GROUPS(2), .NV_ALWAYS(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Valid(valid1), .Stall(stall), .Flush(flush),
    .Conditional(cond), .ALUFlags(alu), .FlagW(flagw), .PCS(pcs), .RegW(regw),
    .MemW(memw), .NoWrite(nowrite), .CntClr(cntclr), .PCSource(pc1),
    .RegWrite(rw1), .MemWrite(mw1), .CondEx(ce1), .Flags(fl1),
    .ExecCount(ex1), .SquashCount(sq1)
  );

  cond_logic_pipe #(.FLAG_GROUPS(2), .NV_ALWAYS(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .Valid(valid2), .Stall(stall), .Flush(flush),
    .Conditional(cond), .ALUFlags(alu), .FlagW(flagw), .PCS(pcs), .RegW(regw),
    .MemW(memw), .NoWrite(nowrite), .CntClr(cntclr), .PCSource(pc2),
    .RegWrite(rw2), .MemWrite(mw2), .CondEx(ce2), .Flags(fl2),
    .ExecCount(ex2), .SquashCount(sq2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid1 = 0; valid2 = 0; stall = 0; flush = 0; cond = 4'b1110;
    alu = '0; flagw = '0; pcs = 0; regw = 0; memw = 0; nowrite = 0; cntclr = 0;
    #12;
    check("rst_flags", 32'(fl1), 32'h0);
    check("rst_exec", 32'(ex1), 32'h0);
    check("rst_squash", 32'(sq1), 32'h0);
    check("rst_regwrite", 32'(rw1), 32'h0);
    #1 rst = 1'b0;

    // EQ with Z=0 squashes
    valid1 = 1; cond = 4'b0000; regw = 1; #1;
    check("eq_condex", 32'(ce1), 32'h0);
    check("eq_regwrite", 32'(rw1), 32'h0);
    step();
    check("eq_squash", 32'(sq1), 32'h1);
    check("eq_exec", 32'(ex1), 32'h0);

    cond = 4'b1110; #1;
    check("al_regwrite", 32'(rw1), 32'h1);
    step();
    check("al_exec", 32'(ex1), 32'h1);

    // group writes
    regw = 0; flagw = 2'b10; alu = 4'b1111; step();
    check("grp_hi", 32'(fl1), 32'hC);
    flagw = 2'b01; alu = 4'b0011; step();
    check("grp_lo", 32'(fl1), 32'hF);
    check("grp_exec", 32'(ex1), 32'h3);

    // SUBS then dependent BEQ back-to-back
    flagw = 2'b11; alu = 4'b0100; step();
    check("subs_flags", 32'(fl1), 32'h4);
    flagw = 2'b00; cond = 4'b0000; pcs = 1; #1;
    check("beq_condex", 32'(ce1), 32'h1);
    check("beq_pcsource", 32'(pc1), 32'h1);
    step();
    check("beq_exec", 32'(ex1), 32'h5);
    pcs = 0;

    // Flags = Z only: GT false, HI false, LS true, LE true
    valid1 = 0;
    cond = 4'b1100; #1; check("gt_z", 32'(ce1), 32'h0);
    cond = 4'b1000; #1; check("hi_z", 32'(ce1), 32'h0);
    cond = 4'b1001; #1; check("ls_z", 32'(ce1), 32'h1);
    cond = 4'b1101; #1; check("le_z", 32'(ce1), 32'h1);
    cond = 4'b0001; #1; check("ne_z", 32'(ce1), 32'h0);

    // Stall three cycles then commit once
    valid1 = 1; cond = 4'b1110; memw = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_memwrite", 32'(mw1), 32'h0);
      check("stall_condex", 32'(ce1), 32'h1);
      step();
      check("stall_exec", 32'(ex1), 32'h5);
    end
    stall = 0; #1;
    check("unstall_memwrite", 32'(mw1), 32'h1);
    step();
    check("unstall_exec", 32'(ex1), 32'h6);

    // Flush: nothing commits, flags held
    flush = 1; flagw = 2'b11; alu = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("flush_memwrite", 32'(mw1), 32'h0);
      step();
      check("flush_exec", 32'(ex1), 32'h6);
      check("flush_flags", 32'(fl1), 32'h4);
    end
    flush = 0; memw = 0;

    // NoWrite: register write suppressed, flags and counter still advance
    nowrite = 1; regw = 1; alu = 4'b1001; #1;
    check("nowrite_regwrite", 32'(rw1), 32'h0);
    step();
    check("nowrite_flags", 32'(fl1), 32'h9);
    check("nowrite_exec", 32'(ex1), 32'h7);
    nowrite = 0; flagw = 2'b00;

    // Clear wins over a simultaneous increment
    cntclr = 1; step();
    check("clr_exec", 32'(ex1), 32'h0);
    check("clr_squash", 32'(sq1), 32'h0);
    cntclr = 0;

    // NV: never on default instance, always on the other
    valid2 = 1; cond = 4'b1111; regw = 1; #1;
    check("nv0_regwrite", 32'(rw1), 32'h0);
    check("nv1_regwrite", 32'(rw2), 32'h1);
    step();
    check("nv0_squash", 32'(sq1), 32'h1);
    check("sat_exec_1", 32'(ex2), 32'h1);

    valid1 = 0; cond = 4'b1110;
    step(); check("sat_exec_2", 32'(ex2), 32'h2);
    step(); check("sat_exec_3", 32'(ex2), 32'h3);
    step(); check("sat_exec_4", 32'(ex2), 32'h3);
    step(); check("sat_exec_5", 32'(ex2), 32'h3);
    cntclr = 1; step();
    check("sat_clr", 32'(ex2), 32'h0);
    cntclr = 0;

    // Asynchronous reset mid-cycle discards a pending flag write
    valid1 = 1; flagw = 2'b11; alu = 4'b1111; #2;
    rst = 1; #1;
    check("arst_exec", 32'(ex2), 32'h0);
    check("arst_flags", 32'(fl1), 32'h0);
    #1 rst = 0; valid1 = 0; valid2 = 0;
    @(negedge clk);
    check("arst_flags_hold", 32'(fl1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
